spi_master_param: RTL

SPI_MASTER_PARAM -- requirements
Module: spi_master_param

---
 rtl/spi_master_param.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_param.sv
// spi_master_param: parameterised SPI master, one frame per request.
//
// Parameters:
//   DATA_W    frame width in bits (1..32)
//   CLK_DIV   clk cycles per sclk half-period (>=1)
//   LSB_FIRST 1 = bit 0 shifted first, 0 = bit DATA_W-1 shifted first
//
// Ports:
//   clk   in   single clock, all logic on its rising edge
//   rst   in   synchronous active-high reset
//   newd  in   transfer request, honoured only while idle and not busy
//   din   in   transmit word, latched at accept
//   cpol  in   sclk idle level, latched at accept
//   cpha  in   0 = sample on leading edge, 1 = sample on trailing edge
//   miso  in   serial receive data
//   sclk  out  serial clock (registered)
//   cs    out  active-low chip select (registered)
//   mosi  out  serial transmit data (registered)
//   dout  out  last completed received word
//   busy  out  high from the cycle after accept through the done cycle
//   done  out  one-cycle completion pulse
module spi_master_param #(
  parameter int DATA_W    = 12,
  parameter int CLK_DIV   = 10,
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              newd,
  input  logic [DATA_W-1:0] din,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              miso,
  output logic              sclk,
  output logic              cs,
  output logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);

  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);

  typedef enum logic [1:0] {IDLE, XFER, HOLD} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic                sclk_q, sclk_d;
  logic                cs_q, cs_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [EDGE_W-1:0]   edge_k;
  logic                leading;
  logic                do_sample;
  logic                do_advance;

  function automatic logic first_bit(input logic [DATA_W-1:0] v);
    if (LSB_FIRST != 0) return v[0];
    else                return v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v);
    if (LSB_FIRST != 0) return v >> 1;
    else                return v << 1;
  endfunction

  // Received bits land so that the first bit ends up in the same position
  // it was transmitted from.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v,
                                                 input logic b);
    logic [DATA_W-1:0] r;
    if (LSB_FIRST != 0) begin
      r = v >> 1;
      r[DATA_W-1] = b;
    end else begin
      r = v << 1;
      r[0] = b;
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_d     = edge_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    dout_d     = dout_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    sclk_d     = sclk_q;
    cs_d       = cs_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    edge_k     = edge_q + EDGE_W'(1);
    leading    = edge_k[0];
    do_sample  = cpha_q ? !leading : leading;
    do_advance = cpha_q ? leading : (!leading && (edge_k != EDGE_LAST));

    case (state_q)
      IDLE: begin
        // busy_q is still high in the done cycle, which blocks a request there
        busy_d = 1'b0;
        if (!busy_q && newd) begin
          state_d = XFER;
          cpol_d  = cpol;
          cpha_d  = cpha;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          sclk_d  = cpol;
          cnt_d   = '0;
          edge_d  = '0;
          rx_d    = '0;
          if (!cpha) begin
            mosi_d = first_bit(din);
            tx_d   = shift_out(din);
          end else begin
            mosi_d = 1'b0;
            tx_d   = din;
          end
        end
      end
      XFER: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_k;
          if (do_sample) rx_d = shift_in(rx_q, miso);
          if (do_advance) begin
            mosi_d = first_bit(tx_q);
            tx_d   = shift_out(tx_q);
          end
          if (edge_k == EDGE_LAST) state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == DIV_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          edge_d  = '0;
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          dout_d  = rx_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sclk = sclk_q;
  assign cs   = cs_q;
  assign mosi = mosi_q;
  assign dout = dout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
